pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 109 ++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch front end with a PC register, a redirect mux and a
// three-state fetch FSM (IDLE -> REQ -> EXEC).
// Each fetch requests the word at PC and holds the request until memory acknowledges.
// The fetched word is then registered and handed to decode.
// When decode releases it, PC advances to the highest-priority redirect or to PC+1.
// Optional build macro JR_EN adds the JumpReg/RegTarget register-jump redirect
// at the highest priority; without it that port pair does not exist.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] PCJump,
`ifdef JR_EN
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
`endif
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus1
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   pc_p0, pc_nxt;
    logic [DATA_W-1:0]   instr_p1, instr_nxt;
    logic [DATA_W-1:0]   redirect_pc;

    // Word-address increment; wraps naturally modulo 2^32.
    function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
        return pc + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // Select the next sequential-or-redirected PC by fixed priority.
    always_comb begin
        redirect_pc = pc_inc(pc_p0);
        if (Branch)
            redirect_pc = BranchTarget;
        if (Jump)
            redirect_pc = PCJump;
`ifdef JR_EN
        if (JumpReg)
            redirect_pc = RegTarget;
`endif
    end

    // Fetch FSM next-state and datapath load enables.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_p0;
        instr_nxt = instr_p1;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (IMemAck) begin
                    instr_nxt = IMemData;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (!Stall) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0/p1 registers: FSM state, PC and delivered instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc_p0    <= RESET_PC;
            instr_p1 <= '0;
        end else begin
            state    <= state_nxt;
            pc_p0    <= pc_nxt;
            instr_p1 <= instr_nxt;
        end
    end

    // Outputs decoded from state; the address is always the current PC.
    always_comb begin
        IMemReq    = (state == REQ);
        InstrValid = (state == EXEC);
        IMemAddr   = pc_p0;
        PC         = pc_p0;
        PCPlus1    = pc_inc(pc_p0);
        Instr      = instr_p1;
    end

endmodule
